mem_port_arbiter3: RTL and testbench
====================================

Name: mem_port_arbiter3

Overview:
- Round-robin arbiter sharing one memory/bus port between three requesters: 0 = instruction fetch, 1 = load/store unit, 2 = debug/DMA.
- Generates the 2-bit select for the team's 3-to-1 data mux on the request path (addr/wdata/we), so the mux encoding is fixed: 00 = req0, 01 = req1, 10 = req2, 11 = illegal.
- Holds a grant for one full transaction, from request acceptance to memory response, and routes the response valid back to the owner.

Parameters:
- DATA_WIDTH, 32, width of rdata returned to requesters.
- TIMEOUT_CYCLES, 64, max BUSY cycles before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_i  in  3  per-requester request, held high until granted
- gnt_o  out  3  one-hot grant; pulses for exactly the acceptance cycle
- sel_o  out  2  mux select driving the shared request-path mux
- mem_req_o  out  1  request valid to memory port
- mem_ready_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory response data
- rvalid_o  out  3  one-hot response valid to the owning requester
- rdata_o  out  DATA_WIDTH  broadcast response data (qualified by rvalid_o)
- busy_o  out  1  transaction outstanding
- timeout_o  out  1  single-cycle pulse on forced release (tied 0 if feature absent)

Behaviour:
- States: IDLE, REQ (request presented, waiting mem_ready_i), WAIT (accepted, waiting mem_rvalid_i).
- Reset (synchronous, active-high): state = IDLE, sel_o = 2'b00, owner = 0, last-granted pointer = 2 (req0 has highest priority first), gnt_o = 0, mem_req_o = 0, rvalid_o = 0, busy_o = 0, timeout_o = 0.
- IDLE:
  - If any req_i is high, pick the first set bit searching upward cyclically from last+1.
  - Register owner and sel_o; move to REQ on the next edge.
  - If no request, stay in IDLE with sel_o unchanged.
- REQ:
  - mem_req_o = 1 and busy_o = 1.
  - When mem_ready_i = 1: gnt_o[owner] = 1 for that cycle, last = owner, go to WAIT.
- WAIT:
  - mem_req_o = 0 and busy_o = 1.
  - When mem_rvalid_i = 1: rvalid_o[owner] = 1 combinationally, rdata_o = mem_rdata_i, go to IDLE.
- Latency: request sampled in IDLE gives mem_req_o on the following cycle. Minimum turnaround (ready and rvalid each in their first cycle) is 3 cycles per transaction; back-to-back arbitration restarts from IDLE.
- sel_o is stable from REQ entry through WAIT exit; it never changes while busy_o = 1.
- sel_o never takes the value 2'b11.
- Requests arriving or dropping during REQ/WAIT are ignored until IDLE. Dropping req_i before the grant is a protocol violation; the arbiter still completes the transaction.
- Fairness: with all three requests continuously high, the grant order is 0,1,2,0,1,2...
- mem_rvalid_i seen in IDLE or REQ: ignored, no rvalid_o.
- mem_ready_i and mem_rvalid_i both high in REQ: accept only; rvalid is honoured from WAIT onward.
- Reset asserted mid-transaction: return to IDLE next edge; the outstanding response is dropped.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entering REQ and increments each REQ/WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: timeout_o pulses for one cycle, no rvalid_o, last = owner, state = IDLE.
  - A late mem_rvalid_i arriving in IDLE is ignored.
- Undefined: no counter; timeout_o tied 0; the arbiter waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t
  - localparams SEL_REQ0 = 2'b00, SEL_REQ1 = 2'b01, SEL_REQ2 = 2'b10, shared with the mux instantiation site
  - NUM_REQ = 3
- Sub-module rr_pick3: a combinational round-robin priority picker with inputs req[2:0] and last[1:0], and outputs valid and idx[1:0]. It is reusable and unit-testable on its own.

Test Plan:
- Reset then req_i = 3'b010, ready and rvalid each in their first cycle:
  - mem_req_o rises cycle 1, sel_o = 01.
  - gnt_o = 010 on cycle 1, rvalid_o = 010 with rdata_o = 0xDEADBEEF on cycle 2.
  - busy_o low on cycle 3.
- req_i = 3'b111 held for 6 transactions: grant sequence 0,1,2,0,1,2; sel_o sequence 00,01,10,00,01,10.
- req1 in WAIT with mem_ready_i delayed 5 cycles and rvalid delayed 3; req0 and req2 toggle meanwhile: sel_o stays 01 throughout, and no gnt_o or rvalid_o to 0 or 2.
- Assert reset during WAIT with rvalid arriving the next cycle: outputs return to reset values, rvalid_o stays 0, sel_o = 00.
- mem_ready_i and mem_rvalid_i both high on the REQ cycle: only gnt_o asserts; rvalid_o asserts on the first WAIT cycle with rvalid.
- With MEM_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES = 8, req2 granted with rvalid never returned:
  - timeout_o pulses once, 8 cycles after REQ entry.
  - Arbiter is in IDLE on the next cycle, and a pending req0 is served next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-requester memory port arbiter.
// The select encoding here is also used by the request-path mux instantiation.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } arb_state_t;

    // One-hot vector for a requester index; index 3 maps to no requester.
    function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
        logic [NUM_REQ-1:0] vec;
        case (idx)
            SEL_REQ0: vec = 3'b001;
            SEL_REQ1: vec = 3'b010;
            SEL_REQ2: vec = 3'b100;
            default:  vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Searches upward cyclically starting at last+1; last = 3 is treated like 2.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

    // Priority order derived from the last granted requester, then first-hit select.
    always_comb begin
        first  = SEL_REQ0;
        second = SEL_REQ1;
        third  = SEL_REQ2;
        case (last)
            2'd0: begin
                first  = SEL_REQ1;
                second = SEL_REQ2;
                third  = SEL_REQ0;
            end
            2'd1: begin
                first  = SEL_REQ2;
                second = SEL_REQ0;
                third  = SEL_REQ1;
            end
            default: begin
                first  = SEL_REQ0;
                second = SEL_REQ1;
                third  = SEL_REQ2;
            end
        endcase

        valid = |req;
        idx   = SEL_REQ0;
        if ((req & onehot3(first)) != 3'b000) begin
            idx = first;
        end else if ((req & onehot3(second)) != 3'b000) begin
            idx = second;
        end else if ((req & onehot3(third)) != 3'b000) begin
            idx = third;
        end
    end

endmodule

// File: rtl/mem_port_arbiter3.sv
// Round-robin arbiter sharing one memory port between fetch (0), LSU (1) and
// debug/DMA (2). Holds the grant from request acceptance to memory response.
// Optional forced release after TIMEOUT_CYCLES busy cycles: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter3
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req_i,
    output logic [2:0]            gnt_o,
    output logic [1:0]            sel_o,
    output logic                  mem_req_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [2:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    arb_state_t state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;

    logic       pick_valid;
    logic [1:0] pick_idx;

    logic [2:0] gnt_c;
    logic [2:0] rvalid_c;
    logic       timeout_c;
    logic       timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Parameter is only meaningful when the timeout feature is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    rr_pick3 u_pick (
        .req   (req_i),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state, owner tracking and per-cycle pulses.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_c     = 3'b000;
        rvalid_c  = 3'b000;
        timeout_c = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = REQ;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (timeout_hit) begin
                    timeout_c = 1'b1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end else if (mem_ready_i) begin
                    gnt_c   = onehot3(owner_q);
                    last_d  = owner_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (mem_rvalid_i) begin
                    rvalid_c = onehot3(owner_q);
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    timeout_c = 1'b1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= SEL_REQ0;
            last_q  <= SEL_REQ2;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Busy-cycle counter for forced release.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Owner index doubles as the mux select; encodings are identical.
    assign sel_o     = owner_q;
    assign mem_req_o = (state_q == REQ);
    assign busy_o    = (state_q == REQ) || (state_q == WAIT);
    assign rdata_o   = mem_rdata_i;

    // Handshake pulses are suppressed while reset is asserted.
    assign gnt_o     = reset ? 3'b000 : gnt_c;
    assign rvalid_o  = reset ? 3'b000 : rvalid_c;
    assign timeout_o = reset ? 1'b0   : timeout_c;

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Directed bench for mem_port_arbiter3 (timeout scenario when MEM_ARB_TIMEOUT_EN).
module tb_mem_port_arbiter3;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic        mem_req;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata_in;
    logic [2:0]  rvalid_out;
    logic [31:0] rdata_out;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter3 #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req),
        .gnt_o        (gnt),
        .sel_o        (sel),
        .mem_req_o    (mem_req),
        .mem_ready_i  (ready),
        .mem_rvalid_i (rvalid),
        .mem_rdata_i  (rdata_in),
        .rvalid_o     (rvalid_out),
        .rdata_o      (rdata_out),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then move to the sampling point.
    task automatic drive(input logic [2:0] r, input logic rdy, input logic rv, input logic [31:0] d);
        req      = r;
        ready    = rdy;
        rvalid   = rv;
        rdata_in = d;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 3'b000; ready = 1'b0; rvalid = 1'b0; rdata_in = 32'h0;
        adv();
        reset = 1'b0;
    endtask

    logic [1:0] exp_idx;
    logic [2:0] exp_oh;
    logic [2:0] tog;

    initial begin
        reset = 1'b1;
        req = 3'b000; ready = 1'b0; rvalid = 1'b0; rdata_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, with a spurious rvalid applied under reset.
        drive(3'b111, 1'b1, 1'b1, 32'h1);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_rvalid", 32'(rvalid_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        adv();
        reset = 1'b0;

        // Single LSU transaction, minimum turnaround.
        drive(3'b010, 1'b0, 1'b0, 32'h0);
        check("t1_c0_mem_req", 32'(mem_req), 32'h0);
        adv();
        drive(3'b010, 1'b1, 1'b0, 32'h0);
        check("t1_c1_mem_req", 32'(mem_req), 32'h1);
        check("t1_c1_sel", 32'(sel), 32'h1);
        check("t1_c1_gnt", 32'(gnt), 32'h2);
        check("t1_c1_busy", 32'(busy), 32'h1);
        adv();
        drive(3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
        check("t1_c2_rvalid", 32'(rvalid_out), 32'h2);
        check("t1_c2_rdata", rdata_out, 32'hDEADBEEF);
        check("t1_c2_mem_req", 32'(mem_req), 32'h0);
        check("t1_c2_busy", 32'(busy), 32'h1);
        adv();
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        check("t1_c3_busy", 32'(busy), 32'h0);
        check("t1_c3_rvalid", 32'(rvalid_out), 32'h0);
        adv();

        // Fairness: all three requesting, six transactions.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            exp_idx = 2'(t % 3);
            exp_oh  = 3'b001 << exp_idx;
            drive(3'b111, 1'b0, 1'b0, 32'h0);
            adv();
            drive(3'b111, 1'b1, 1'b0, 32'h0);
            check($sformatf("rr%0d_sel", t), 32'(sel), 32'(exp_idx));
            check($sformatf("rr%0d_gnt", t), 32'(gnt), 32'(exp_oh));
            adv();
            drive(3'b111, 1'b0, 1'b1, 32'h100 + 32'(t));
            check($sformatf("rr%0d_rvalid", t), 32'(rvalid_out), 32'(exp_oh));
            adv();
        end

        // LSU with slow ready/rvalid while others toggle; spurious rvalid in REQ.
        do_reset();
        drive(3'b010, 1'b0, 1'b0, 32'h0);
        adv();
        for (int k = 0; k < 5; k++) begin
            tog = k[0] ? 3'b101 : 3'b000;
            drive(3'b010 | tog, 1'b0, (k == 2), 32'h0);
            check($sformatf("hold_req%0d_sel", k), 32'(sel), 32'h1);
            check($sformatf("hold_req%0d_gnt", k), 32'(gnt), 32'h0);
            check($sformatf("hold_req%0d_rvalid", k), 32'(rvalid_out), 32'h0);
            check($sformatf("hold_req%0d_mem_req", k), 32'(mem_req), 32'h1);
            adv();
        end
        drive(3'b111, 1'b1, 1'b0, 32'h0);
        check("hold_gnt", 32'(gnt), 32'h2);
        check("hold_gnt_sel", 32'(sel), 32'h1);
        adv();
        for (int k = 0; k < 3; k++) begin
            tog = k[0] ? 3'b000 : 3'b101;
            drive(tog, 1'b0, 1'b0, 32'h0);
            check($sformatf("hold_wait%0d_sel", k), 32'(sel), 32'h1);
            check($sformatf("hold_wait%0d_rvalid", k), 32'(rvalid_out), 32'h0);
            check($sformatf("hold_wait%0d_gnt", k), 32'(gnt), 32'h0);
            check($sformatf("hold_wait%0d_busy", k), 32'(busy), 32'h1);
            adv();
        end
        drive(3'b101, 1'b0, 1'b1, 32'h12345678);
        check("hold_rvalid", 32'(rvalid_out), 32'h2);
        check("hold_rdata", rdata_out, 32'h12345678);
        adv();
        drive(3'b000, 1'b0, 1'b1, 32'h0);
        check("idle_rvalid_ignored", 32'(rvalid_out), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_sel_kept", 32'(sel), 32'h1);
        adv();

        // Reset during WAIT; response arrives after reset.
        drive(3'b100, 1'b0, 1'b0, 32'h0);
        adv();
        drive(3'b000, 1'b1, 1'b0, 32'h0);
        check("rw_gnt", 32'(gnt), 32'h4);
        check("rw_sel", 32'(sel), 32'h2);
        adv();
        reset = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        check("rw_wait_rvalid", 32'(rvalid_out), 32'h0);
        adv();
        reset = 1'b0;
        drive(3'b000, 1'b0, 1'b1, 32'hCAFEF00D);
        check("rw_post_rvalid", 32'(rvalid_out), 32'h0);
        check("rw_post_sel", 32'(sel), 32'h0);
        check("rw_post_busy", 32'(busy), 32'h0);
        check("rw_post_mem_req", 32'(mem_req), 32'h0);
        check("rw_post_gnt", 32'(gnt), 32'h0);
        adv();

        // ready and rvalid together in REQ: accept only.
        drive(3'b001, 1'b0, 1'b0, 32'h0);
        adv();
        drive(3'b001, 1'b1, 1'b1, 32'hAAAA5555);
        check("both_gnt", 32'(gnt), 32'h1);
        check("both_rvalid", 32'(rvalid_out), 32'h0);
        adv();
        drive(3'b000, 1'b0, 1'b1, 32'h5555AAAA);
        check("both_wait_rvalid", 32'(rvalid_out), 32'h1);
        check("both_wait_rdata", rdata_out, 32'h5555AAAA);
        check("both_wait_timeout", 32'(timeout), 32'h0);
        adv();
        drive(3'b000, 1'b0, 1'b0, 32'h0);
        adv();

`ifdef MEM_ARB_TIMEOUT_EN
        // Forced release: req2 never gets a response, req0 pending.
        do_reset();
        drive(3'b100, 1'b0, 1'b0, 32'h0);
        adv();
        drive(3'b001, 1'b1, 1'b0, 32'h0);
        check("to_gnt", 32'(gnt), 32'h4);
        check("to_c0_timeout", 32'(timeout), 32'h0);
        adv();
        for (int k = 1; k < 8; k++) begin
            drive(3'b001, 1'b0, 1'b0, 32'h0);
            check($sformatf("to_c%0d_timeout", k), 32'(timeout), (k == 7) ? 32'h1 : 32'h0);
            check($sformatf("to_c%0d_rvalid", k), 32'(rvalid_out), 32'h0);
            check($sformatf("to_c%0d_sel", k), 32'(sel), 32'h2);
            adv();
        end
        drive(3'b001, 1'b0, 1'b1, 32'h0);
        check("to_idle_busy", 32'(busy), 32'h0);
        check("to_idle_timeout", 32'(timeout), 32'h0);
        check("to_idle_rvalid", 32'(rvalid_out), 32'h0);
        adv();
        drive(3'b001, 1'b0, 1'b0, 32'h0);
        check("to_next_sel", 32'(sel), 32'h0);
        check("to_next_mem_req", 32'(mem_req), 32'h1);
        adv();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
